shared_interval_timer: RTL and testbench

- Round-robin arbiter and sequencer that shares one programmable down-counter timer between NUM_REQ requesters (game-logic blocks needing delays: serve delay, brick flash, score blink).
- Counting is gated by an external tick enable, normally the TRIG_OUT of an upstream prescaler counter.
- One requester owns the timer at a time. It receives a one-cycle DONE pulse when its interval expires.

---
 rtl/shared_interval_timer.sv | 109 ++++++++++
 tb/tb_shared_interval_timer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shared_interval_timer.sv
// Round-robin sharing of one programmable down-counter between NUM_REQ requesters.
// The owner gets a one-cycle DONE pulse when its interval expires; dropping REQ aborts.

module sit_slot #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   req,
  input  logic                   done,
  input  logic [COUNT_WIDTH-1:0] load_slice,
  output logic                   elig,
  output logic [COUNT_WIDTH-1:0] load
);
  // A requester still holding REQ in its DONE cycle must not win again.
  assign elig = req & ~done;
  assign load = load_slice;
endmodule

module shared_interval_timer #(
  parameter int NUM_REQ      = 4,
  parameter int COUNT_WIDTH  = 16,
  parameter int REQ_ID_WIDTH = 2
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           TICK_IN,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] LOAD_VALUE,
  output logic [NUM_REQ-1:0]             GRANT,
  output logic [NUM_REQ-1:0]             DONE,
  output logic                           BUSY,
  output logic [COUNT_WIDTH-1:0]         COUNT,
  output logic [REQ_ID_WIDTH-1:0]        OWNER
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t                                state;
  logic [REQ_ID_WIDTH-1:0]               last;
  logic [NUM_REQ-1:0]                    elig;
  logic [NUM_REQ-1:0][COUNT_WIDTH-1:0]   load_arr;
  logic                                  found;
  logic [REQ_ID_WIDTH-1:0]               win;
  int                                    idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    sit_slot #(.COUNT_WIDTH(COUNT_WIDTH)) u_slot (
      .req        (REQ[g]),
      .done       (DONE[g]),
      .load_slice (LOAD_VALUE[g*COUNT_WIDTH +: COUNT_WIDTH]),
      .elig       (elig[g]),
      .load       (load_arr[g])
    );
  end

  // Scan last+1, last+2, ... so the most recent owner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = REQ_ID_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      GRANT <= '0;
      DONE  <= '0;
      BUSY  <= 1'b0;
      COUNT <= '0;
      OWNER <= '0;
      last  <= REQ_ID_WIDTH'(NUM_REQ - 1);
    end else begin
      DONE <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state <= RUN;
            GRANT <= NUM_REQ'(1) << win;
            OWNER <= win;
            BUSY  <= 1'b1;
            COUNT <= load_arr[win];
          end
        end
        RUN: begin
          if (!REQ[OWNER]) begin
            state <= IDLE;
            GRANT <= '0;
            BUSY  <= 1'b0;
            last  <= OWNER;
          end else if (COUNT == '0) begin
            state <= IDLE;
            GRANT <= '0;
            BUSY  <= 1'b0;
            DONE  <= NUM_REQ'(1) << OWNER;
            last  <= OWNER;
          end else if (TICK_IN) begin
            COUNT <= COUNT - COUNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_interval_timer.sv
// Bench for shared_interval_timer: vector table, corner sequences, DONE scoreboard.

module tb_shared_interval_timer;
  localparam int NR = 4;
  localparam int CW = 16;
  localparam int IW = 2;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               TICK_IN;
  logic [NR-1:0]      REQ;
  logic [NR*CW-1:0]   LOAD_VALUE;
  logic [NR-1:0]      GRANT, DONE;
  logic               BUSY;
  logic [CW-1:0]      COUNT;
  logic [IW-1:0]      OWNER;

  shared_interval_timer #(.NUM_REQ(NR), .COUNT_WIDTH(CW), .REQ_ID_WIDTH(IW)) dut (
    .CLK(CLK), .RESET(RESET), .TICK_IN(TICK_IN), .REQ(REQ), .LOAD_VALUE(LOAD_VALUE),
    .GRANT(GRANT), .DONE(DONE), .BUSY(BUSY), .COUNT(COUNT), .OWNER(OWNER)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  typedef struct {
    logic [NR-1:0] req;
    int            idx;
    logic [CW-1:0] val;
    logic          tick;
    int            delta;   // edges from grant edge to the edge raising DONE
  } vec_t;

  typedef struct {
    logic [NR-1:0] done;
    int            delta;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  int            grant_cyc = 0;
  logic [NR-1:0] prev_grant = '0;
  vec_t          vecs[5];
  int            done_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (RESET) begin
      chk("invariants", {31'd0, $onehot0(GRANT) && $onehot0(DONE) && ((GRANT & DONE) == '0)
                                && (BUSY == (GRANT != '0))}, 32'd1);
      if (GRANT != '0 && GRANT != prev_grant) grant_cyc = cyc;
      if (DONE != '0) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'(DONE), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("done_vec", 32'(DONE), 32'(e.done));
          chk("done_latency", 32'(cyc - grant_cyc), 32'(e.delta));
          chk("done_idle", {27'd0, GRANT, BUSY}, 32'd0);
        end
      end
      prev_grant = GRANT;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{req: 4'b0010, idx: 1, val: 16'd3, tick: 1'b1, delta: 4};
    vecs[1] = '{req: 4'b0001, idx: 0, val: 16'd0, tick: 1'b0, delta: 1};
    vecs[2] = '{req: 4'b0100, idx: 2, val: 16'd0, tick: 1'b0, delta: 1};
    vecs[3] = '{req: 4'b1000, idx: 3, val: 16'd5, tick: 1'b1, delta: 6};
    vecs[4] = '{req: 4'b0001, idx: 0, val: 16'd1, tick: 1'b1, delta: 2};

    RESET = 1'b0; TICK_IN = 1'b0; REQ = '0; LOAD_VALUE = '0;
    fork
      forever begin
        @(negedge CLK);
        monitor();
      end
    join_none
    @(negedge CLK);
    chk("reset_outs", {13'd0, GRANT, DONE, BUSY, OWNER, 8'd0} | 32'(COUNT), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // table: single requester intervals
    foreach (vecs[n]) begin
      LOAD_VALUE = '0;
      LOAD_VALUE[vecs[n].idx*CW +: CW] = vecs[n].val;
      TICK_IN = vecs[n].tick;
      exp_q.push_back('{done: NR'(1) << vecs[n].idx, delta: vecs[n].delta});
      REQ = vecs[n].req;
      for (int i = 0; i < 20 && GRANT == '0; i++) @(negedge CLK);
      chk("vec_grant", 32'(GRANT), 32'(vecs[n].req));
      chk("vec_load", 32'(COUNT), 32'(vecs[n].val));
      chk("vec_owner", 32'(OWNER), 32'(vecs[n].idx));
      for (int i = 0; i < 100 && DONE == '0; i++) @(negedge CLK);
      chk("vec_done_seen", {31'd0, DONE != '0}, 32'd1);
      REQ = '0;
      @(negedge CLK);
    end

    // sparse tick: one tick every 4th cycle, V=2 for requester 0
    LOAD_VALUE = '0; LOAD_VALUE[0 +: CW] = 16'd2; TICK_IN = 1'b0;
    exp_q.push_back('{done: 4'b0001, delta: 9});
    REQ = 4'b0001;
    for (int i = 0; i < 20 && GRANT == '0; i++) @(negedge CLK);
    chk("sparse_grant", 32'(GRANT), 32'h1);
    for (int k = 1; k <= 9; k++) begin
      TICK_IN = (k % 4 == 0);
      @(negedge CLK);
      if (k <= 8) begin
        chk("sparse_count", 32'(COUNT), 32'(2 - (k >= 4 ? 1 : 0) - (k >= 8 ? 1 : 0)));
        chk("sparse_no_early_done", 32'(DONE), 32'd0);
      end else chk("sparse_done", 32'(DONE), 32'h1);
    end
    REQ = '0; TICK_IN = 1'b0;
    @(negedge CLK);

    // round robin from reset, all V=1, REQ held high
    RESET = 1'b0; REQ = 4'b1111; TICK_IN = 1'b1;
    for (int i = 0; i < NR; i++) LOAD_VALUE[i*CW +: CW] = 16'd1;
    @(negedge CLK);
    RESET = 1'b1;
    for (int g = 0; g < 5; g++) exp_q.push_back('{done: NR'(1) << (g % 4), delta: 2});
    done_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 20 && GRANT == '0; i++) @(negedge CLK);
      chk("rr_grant", 32'(GRANT), 32'(NR'(1) << (g % 4)));
      if (g > 0) chk("rr_gap", 32'(cyc - done_cyc), 32'd1);
      for (int i = 0; i < 20 && GRANT != '0; i++) @(negedge CLK);
      chk("rr_done", 32'(DONE), 32'(NR'(1) << (g % 4)));
      done_cyc = cyc;
      if (g == 4) REQ = '0;
    end
    @(negedge CLK);

    // abort: requester 3 drops REQ after 3 ticks; 0 and 1 pending
    LOAD_VALUE = '0;
    LOAD_VALUE[3*CW +: CW] = 16'd10;
    LOAD_VALUE[0 +: CW] = 16'd4;
    LOAD_VALUE[1*CW +: CW] = 16'd6;
    TICK_IN = 1'b1; REQ = 4'b1000;
    for (int i = 0; i < 20 && GRANT == '0; i++) @(negedge CLK);
    chk("abort_grant", 32'(GRANT), 32'h8);
    chk("abort_load", 32'(COUNT), 32'd10);
    REQ = 4'b1011;
    repeat (3) @(negedge CLK);
    chk("abort_pre_count", 32'(COUNT), 32'd7);
    REQ = 4'b0011;
    @(negedge CLK);
    chk("abort_state", {28'd0, GRANT, DONE, BUSY, 3'd0} | 32'(COUNT), 32'd7);
    @(negedge CLK);
    chk("abort_next_grant", 32'(GRANT), 32'h1);
    chk("abort_next_owner", 32'(OWNER), 32'd0);
    chk("abort_next_load", 32'(COUNT), 32'd4);
    REQ = '0;
    repeat (2) @(negedge CLK);

    // asynchronous reset mid-run at COUNT=5
    LOAD_VALUE = '0; LOAD_VALUE[2*CW +: CW] = 16'd20;
    REQ = 4'b0100;
    for (int i = 0; i < 60 && !(BUSY && COUNT == 16'd5); i++) @(negedge CLK);
    chk("rst_reach5", {31'd0, BUSY && COUNT == 16'd5}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("rst_async_outs", {13'd0, GRANT, DONE, BUSY, OWNER, 8'd0} | 32'(COUNT), 32'd0);
    REQ = 4'b1111; LOAD_VALUE[0 +: CW] = 16'd9;
    @(negedge CLK);
    #2 RESET = 1'b1;
    @(negedge CLK);
    chk("rst_first_grant", 32'(GRANT), 32'h1);
    chk("rst_first_load", 32'(COUNT), 32'd9);
    REQ = '0;
    repeat (3) @(negedge CLK);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
